led_pattern_shifter: RTL and testbench
======================================

Name: led_pattern_shifter

Overview:
- Parametrised successor to the 8-LED / 2-switch shift display: drives N_LED outputs with one of four selectable shift patterns.
- Speed comes from four parameterised prescaler periods chosen by Select.
- Adds over the previous generation: a fourth pattern, direction mirroring, a hold/pause input, synchronised switch inputs with automatic pattern restart on change, and step/wrap status pulses.
- Sits between the board switches and the LED bank at top level.

Parameters:
N_LED, 8, number of LED outputs (≥2)
DIV_S0, 25000000, clock cycles per step for Select=0 (slowest)
DIV_S1, 2500000, cycles per step for Select=1
DIV_S2, 250000, cycles per step for Select=2
DIV_S3, 25000, cycles per step for Select=3 (fastest); all DIV_Sx ≥1, prescaler width = clog2(max DIV_Sx)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Select  in  2  speed select (asynchronous switch)
MODE  in  2  pattern select (asynchronous switch)
dir  in  1  0: pattern moves toward MSB; 1: output bit-reversed (toward LSB)
hold  in  1  1: freeze pattern and prescaler
LED  out  N_LED  registered LED drive
step  out  1  one-cycle pulse on every pattern advance
wrap  out  1  one-cycle pulse, coincident with step, when the phase returns to 0

Behaviour:
- Reset (reset=0, async): LED=0, step=0, wrap=0, prescaler cnt=0, phase k=0, all synchroniser flops=0.
- Synchronisers: Select, MODE, dir, hold each pass through 2 flops. Internal use sees only synchronised values, so an input change takes effect 2 edges later.
- Prescaler: P = DIV_S[Select_sync].
  - When hold_sync=0: cnt increments each cycle. When cnt==P-1, tick=1 and cnt←0 on that edge.
  - When hold_sync=1: cnt and k frozen, no tick, LED unchanged.
  - With P=1, tick fires every cycle.
- On tick (single edge): LED←R(pat(MODE_sync,k)); k←(k==L-1)?0:k+1; step←1; wrap←(k==L-1). Otherwise step=wrap=0.
- R = identity when dir_sync=0, bit reversal when dir_sync=1. The first non-zero LED appears P cycles after reset release.
- Patterns (bit i = LED[i]):
  - MODE 0, running dot: pat=1<<k, L=N_LED.
  - MODE 1, fill/drain: k<N_LED → lowest k+1 bits set; k≥N_LED → lowest 2N_LED-1-k bits set (k=2N_LED-1 gives 0). L=2N_LED.
  - MODE 2, bounce: k<N_LED → 1<<k; else 1<<(2N_LED-2-k). L=2N_LED-2. Ends never repeat consecutively.
  - MODE 3, converge: bits k and N_LED-1-k set. L=ceil(N_LED/2). Odd N: last step shows a single centre LED.
- Restart:
  - Trigger: synchronised MODE or Select differs from its own 1-cycle-delayed copy.
  - Action on that edge: cnt←0, k←0, LED←0, step=wrap=0. Net effect: the edge 3 clocks after the raw input change.
  - Restart has priority over a coincident tick.
  - Restart is applied even while hold_sync=1; the cleared state then stays frozen until hold releases.
- A dir change never restarts; mirroring applies from the next tick.
- Phase never exceeds L-1 in any mode; k is always cleared by mode change, so no out-of-range phase can exist.
- Reset asserted mid-pattern clears everything immediately (asynchronous). No output glitch depends on clk.

Test Plan:
Common bench setup: N_LED=8, DIV_S0..S3=16,8,4,2; clk period 20 ns.
1. Reset release, MODE=0, Select=2, dir=0 → first step pulse 4 cycles after sync settles; LED sequence 01,02,04,…,80,01; wrap high with LED=80 step, and exactly every 8 steps.
2. MODE=1, Select=3 → LED 01,03,07,…,FF,7F,3F,…,01,00 then repeats; step every 2 cycles; wrap on the 00 step (16-step period).
3. MODE=2 then dir toggled mid-run → sequence 01,02,…,80,40,…,02,01 (14-step period); after dir=1, next LED is bit-reversed (e.g. phase 3 gives 10 not 08), no restart, k continues.
4. MODE=3 → 81,42,24,18,81…; wrap on 18. Repeat with N_LED=7 → 41,22,14,08.
5. hold=1 for 50 cycles mid-run → LED, step, cnt frozen; on release the remaining cycles of the interrupted period elapse before the next step, with no skipped or duplicated phase.
6. MODE change while hold=1, and reset pulse asserted between clock edges → LED=00 exactly 3 edges after the MODE change and stays 00 while held. Async reset forces LED=00 before the next clk edge. Select change mid-period restarts with the new period.

Source files
------------

// File: rtl/led_pattern_shifter.sv
// rtl/led_pattern_shifter.sv - four-pattern LED shift display with selectable speed
// Switch inputs are double-synchronised; a MODE/Select change restarts the pattern from phase 0.
module led_pattern_shifter #(
  parameter int N_LED  = 8,
  parameter int DIV_S0 = 25000000,
  parameter int DIV_S1 = 2500000,
  parameter int DIV_S2 = 250000,
  parameter int DIV_S3 = 25000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Select,
  input  logic [1:0]       MODE,
  input  logic             dir,
  input  logic             hold,
  output logic [N_LED-1:0] LED,
  output logic             step,
  output logic             wrap
);

  localparam int DMAX01 = (DIV_S0 > DIV_S1) ? DIV_S0 : DIV_S1;
  localparam int DMAX23 = (DIV_S2 > DIV_S3) ? DIV_S2 : DIV_S3;
  localparam int DMAX   = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
  localparam int CW     = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int KW     = $clog2(2 * N_LED);

  logic [1:0]       sel_s1, sel_s2, sel_d;
  logic [1:0]       mode_s1, mode_s2, mode_d;
  logic             dir_s1, dir_s2;
  logic             hold_s1, hold_s2;
  logic [CW-1:0]    cnt, cnt_last;
  logic [KW-1:0]    k, k_last;
  logic [N_LED-1:0] pat, led_next;
  logic             restart, tick, phase_end;
  int               kv;

  always_comb begin
    cnt_last = '0;
    case (sel_s2)
      2'd0:    cnt_last = CW'(DIV_S0 - 1);
      2'd1:    cnt_last = CW'(DIV_S1 - 1);
      2'd2:    cnt_last = CW'(DIV_S2 - 1);
      default: cnt_last = CW'(DIV_S3 - 1);
    endcase
  end

  // Last legal phase of each pattern; k is cleared on every mode change so it never exceeds this.
  always_comb begin
    k_last = '0;
    case (mode_s2)
      2'd0:    k_last = KW'(N_LED - 1);
      2'd1:    k_last = KW'(2 * N_LED - 1);
      2'd2:    k_last = KW'(2 * N_LED - 3);
      default: k_last = KW'((N_LED + 1) / 2 - 1);
    endcase
  end

  assign kv        = int'(k);
  assign restart   = (sel_s2 != sel_d) || (mode_s2 != mode_d);
  assign tick      = !hold_s2 && (cnt == cnt_last);
  assign phase_end = (k == k_last);

  always_comb begin
    pat = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_s2)
        2'd0:    pat[i] = (i == kv);
        2'd1:    pat[i] = (kv < N_LED) ? (i <= kv) : (i < 2 * N_LED - 1 - kv);
        2'd2:    pat[i] = (kv < N_LED) ? (i == kv) : (i == 2 * N_LED - 2 - kv);
        default: pat[i] = (i == kv) || (i == N_LED - 1 - kv);
      endcase
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_next[i] = dir_s2 ? pat[N_LED-1-i] : pat[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_s1  <= '0;
      sel_s2  <= '0;
      sel_d   <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
      mode_d  <= '0;
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
      hold_s1 <= 1'b0;
      hold_s2 <= 1'b0;
    end else begin
      sel_s1  <= Select;
      sel_s2  <= sel_s1;
      sel_d   <= sel_s2;
      mode_s1 <= MODE;
      mode_s2 <= mode_s1;
      mode_d  <= mode_s2;
      dir_s1  <= dir;
      dir_s2  <= dir_s1;
      hold_s1 <= hold;
      hold_s2 <= hold_s1;
    end
  end

  // Restart wins over hold and over a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      k    <= '0;
      LED  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      k    <= '0;
      LED  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (hold_s2) begin
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      k    <= phase_end ? '0 : k + KW'(1);
      LED  <= led_next;
      step <= 1'b1;
      wrap <= phase_end;
    end else begin
      cnt  <= cnt + CW'(1);
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_shifter.sv
// tb/tb_led_pattern_shifter.sv - scoreboard bench for led_pattern_shifter
// Expected step values and edge numbers are queued at stimulus time and checked on each step pulse.
module tb_led_pattern_shifter;

  logic       clk;
  logic       reset;
  logic [1:0] Select, MODE;
  logic       dir, hold;
  logic [7:0] LED;
  logic       step, wrap;
  logic [1:0] sel7, mode7;
  logic       dir7, hold7;
  logic [6:0] led7;
  logic       step7, wrap7;

  led_pattern_shifter #(.N_LED(8), .DIV_S0(16), .DIV_S1(8), .DIV_S2(4), .DIV_S3(2)) dut (
    .clk(clk), .reset(reset), .Select(Select), .MODE(MODE), .dir(dir), .hold(hold),
    .LED(LED), .step(step), .wrap(wrap)
  );

  led_pattern_shifter #(.N_LED(7), .DIV_S0(16), .DIV_S1(8), .DIV_S2(4), .DIV_S3(2)) dut7 (
    .clk(clk), .reset(reset), .Select(sel7), .MODE(mode7), .dir(dir7), .hold(hold7),
    .LED(led7), .step(step7), .wrap(wrap7)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [1:0]       sel;
    logic             dir;
    int               len;
    logic [15:0][7:0] seq;
  } vec_t;

  typedef struct {
    logic [7:0] led;
    logic       wrap;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  vec_t tbl[7];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  bit   checking = 1'b0;
  int   idx7 = 0;
  int   n7 = 0;
  logic [6:0] exp7 [4];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at edge %0d", name, act, expv, edge_cnt);
    end
  endtask

  function automatic int per(input logic [1:0] s);
    case (s)
      2'd0:    return 16;
      2'd1:    return 8;
      2'd2:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] ref_pat(input int m, input int k);
    case (m)
      0:       return 8'h01 << k;
      1:       return (k < 8) ? 8'((9'h1 << (k + 1)) - 1) : (8'hFF >> (k - 7));
      2:       return (k < 8) ? (8'h01 << k) : (8'h01 << (14 - k));
      default: return (8'h01 << k) | (8'h80 >> k);
    endcase
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = x[7-i];
    return y;
  endfunction

  task automatic push(input logic [7:0] l, input logic w, input int at);
    exp_t e;
    e.led  = l;
    e.wrap = w;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) begin
      @(posedge clk);
      #4;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(posedge clk);
      #4;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  // Drives new switches; the restart lands on the third edge, which becomes the phase-0 reference.
  task automatic start_seg(input logic [1:0] m, input logic [1:0] s, input logic d, output int r);
    checking = 1'b0;
    sbq.delete();
    MODE   = m;
    Select = s;
    dir    = d;
    repeat (3) begin
      @(posedge clk);
      #4;
    end
    r = edge_cnt;
    chk("restart_led", int'(LED), 0);
    chk("restart_step", int'(step), 0);
    checking = 1'b1;
  endtask

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (reset && checking) begin
      if (step) begin
        if (sbq.size() == 0) begin
          chk("spurious_step", 1, 0);
        end else begin
          cur = sbq.pop_front();
          chk("led", int'(LED), int'(cur.led));
          chk("wrap", int'(wrap), int'(cur.wrap));
          chk("step_edge", edge_cnt, cur.at);
        end
      end else begin
        chk("wrap_no_step", int'(wrap), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      idx7 = 0;
    end else if (step7) begin
      chk("led7", int'(led7), int'(exp7[idx7]));
      chk("wrap7", int'(wrap7), int'(idx7 == 3));
      idx7 = (idx7 + 1) % 4;
      n7++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int r, r2, p, t1;
    logic [7:0] l;

    exp7[0] = 7'h41; exp7[1] = 7'h22; exp7[2] = 7'h14; exp7[3] = 7'h08;
    sel7 = 2'd3; mode7 = 2'd3; dir7 = 1'b0; hold7 = 1'b0;

    tbl[0] = '{2'd0, 2'd2, 1'b0, 8,  128'({8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01})};
    tbl[1] = '{2'd1, 2'd3, 1'b0, 16, 128'({8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                           8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01})};
    tbl[2] = '{2'd2, 2'd1, 1'b0, 14, 128'({8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01})};
    tbl[3] = '{2'd3, 2'd3, 1'b0, 4,  128'({8'h18, 8'h24, 8'h42, 8'h81})};
    tbl[4] = '{2'd0, 2'd3, 1'b1, 8,  128'({8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80})};
    tbl[5] = '{2'd1, 2'd2, 1'b1, 16, 128'({8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                                           8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80})};
    tbl[6] = '{2'd3, 2'd0, 1'b1, 4,  128'({8'h18, 8'h24, 8'h42, 8'h81})};

    reset = 1'b0; Select = 2'd0; MODE = 2'd0; dir = 1'b0; hold = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #4;
    end
    chk("reset_led", int'(LED), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_led7", int'(led7), 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_seg(tbl[i].mode, tbl[i].sel, tbl[i].dir, r);
      p = per(tbl[i].sel);
      for (int j = 0; j < 2 * tbl[i].len; j++) begin
        push(tbl[i].seq[j % tbl[i].len], (j % tbl[i].len) == tbl[i].len - 1, r + p * (j + 1));
      end
      drain(2 * tbl[i].len * p + 40);
    end

    // Bounce with dir flipped mid-run: the phase keeps going, only the mirroring changes.
    start_seg(2'd2, 2'd3, 1'b0, r);
    for (int j = 0; j < 16; j++) begin
      l = ref_pat(2, j % 14);
      if (j >= 4) l = rev8(l);
      push(l, (j % 14) == 13, r + 2 * (j + 1));
    end
    wait_edge(r + 6);
    dir = 1'b1;
    drain(60);

    // Hold for 50 cycles in the middle of a period: the period resumes where it stopped.
    start_seg(2'd0, 2'd1, 1'b0, r);
    push(8'h01, 1'b0, r + 8);
    push(8'h02, 1'b0, r + 66);
    push(8'h04, 1'b0, r + 74);
    wait_edge(r + 11);
    hold = 1'b1;
    wait_edge(r + 30);
    chk("hold_led", int'(LED), 8'h01);
    wait_edge(r + 61);
    hold = 1'b0;
    drain(100);

    // MODE change while held clears the display three edges later and it stays cleared.
    start_seg(2'd0, 2'd3, 1'b0, r);
    for (int j = 0; j < 4; j++) push(ref_pat(0, j), 1'b0, r + 2 * (j + 1));
    wait_edge(r + 7);
    hold = 1'b1;
    wait_edge(r + 14);
    MODE = 2'd1;
    wait_edge(r + 16);
    chk("held_led_pre", int'(LED), 8'h08);
    wait_edge(r + 17);
    chk("held_restart_led", int'(LED), 0);
    wait_edge(r + 37);
    chk("held_led_stays", int'(LED), 0);
    chk("held_steps_done", sbq.size(), 0);
    t1 = edge_cnt;
    hold = 1'b0;
    for (int j = 0; j < 4; j++) push(ref_pat(1, j), 1'b0, t1 + 4 + 2 * j);
    drain(40);

    // Asynchronous reset between clock edges.
    chk("pre_reset_led_nz", int'(LED != 8'h00), 1);
    checking = 1'b0;
    sbq.delete();
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_led", int'(LED), 0);
    chk("async_reset_step", int'(step), 0);
    chk("async_reset_wrap", int'(wrap), 0);
    chk("async_reset_led7", int'(led7), 0);
    @(posedge clk);
    #4;
    chk("reset_hold_led", int'(LED), 0);
    reset = 1'b1;
    start_seg(2'd1, 2'd3, 1'b0, r);
    for (int j = 0; j < 16; j++) push(ref_pat(1, j), j == 15, r + 2 * (j + 1));
    drain(60);

    // Select change mid-period restarts with the new period.
    start_seg(2'd0, 2'd0, 1'b0, r);
    push(8'h01, 1'b0, r + 16);
    push(8'h02, 1'b0, r + 32);
    drain(60);
    wait_edge(r + 37);
    start_seg(2'd0, 2'd2, 1'b0, r2);
    for (int j = 0; j < 8; j++) push(ref_pat(0, j), j == 7, r2 + 4 * (j + 1));
    drain(60);

    checking = 1'b0;
    chk("n7_steps_seen", int'(n7 >= 8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
